// File: rtl/shift_ex_stage_pkg.sv
// Shared constants and types for the shift execute-stage slice.
// Opcode values and the Shifter mode encoding live here so decode and execute agree.
package shift_ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_SLL = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRA = 4'b0101;
  localparam logic [OP_W-1:0] OP_ROR = 4'b0110;

  // Mode is taken straight from opcode[1:0]; the fourth code is a pass-through.
  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRA  = 2'b01,
    MODE_ROR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_ex_stage_if.sv
// Decode-side inputs, pipeline control and memory-side outputs of the shift execute slice.
// master drives instructions and stall/flush; slave is the execute stage itself.
interface shift_ex_stage_if;
  import shift_ex_stage_pkg::*;

  logic              id_valid;
  logic [OP_W-1:0]   id_opcode;
  logic [REG_W-1:0]  id_rs_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [3:0]        id_imm;
  logic [REG_W-1:0]  id_rd;
  logic              stall;
  logic              flush;

  logic              mem_valid;
  logic [DATA_W-1:0] mem_result;
  logic [REG_W-1:0]  mem_rd;
  logic              mem_illegal;
  logic              z_flag;

  modport master (
    output id_valid, id_opcode, id_rs_addr, id_rs_data, id_imm, id_rd, stall, flush,
    input  mem_valid, mem_result, mem_rd, mem_illegal, z_flag
  );

  modport slave (
    input  id_valid, id_opcode, id_rs_addr, id_rs_data, id_imm, id_rd, stall, flush,
    output mem_valid, mem_result, mem_rd, mem_illegal, z_flag
  );

endinterface

// File: rtl/Shifter.sv
// Combinational 16-bit shifter: SLL zero-fill, SRA sign-fill, ROR rotate right.
// MODE_PASS returns the operand untouched.
module Shifter
  import shift_ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] Shift_In,
  input  logic [3:0]        Shift_val,
  input  mode_e             Mode,
  output logic [DATA_W-1:0] Shift_Out
);

  logic [2*DATA_W-1:0] rot_wide;

  // Rotating a doubled copy keeps the wrapped bits in the low half.
  assign rot_wide = {Shift_In, Shift_In} >> Shift_val;

  always_comb begin
    Shift_Out = Shift_In;
    unique case (Mode)
      MODE_SLL:  Shift_Out = Shift_In << Shift_val;
      MODE_SRA:  Shift_Out = $signed(Shift_In) >>> Shift_val;
      MODE_ROR:  Shift_Out = rot_wide[DATA_W-1:0];
      MODE_PASS: Shift_Out = Shift_In;
      default:   Shift_Out = Shift_In;
    endcase
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Shift execute stage: ID/EX register -> Shifter -> EX/MEM register plus Z flag.
// Define SHIFT_EX_FWD_EN to forward in-flight results into the captured operand.
module shift_ex_stage
  import shift_ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  shift_ex_stage_if.slave bus
);

  logic              idex_valid_reg;
  logic [OP_W-1:0]   idex_opcode_reg;
  logic [DATA_W-1:0] idex_operand_reg;
  logic [3:0]        idex_imm_reg;
  logic [REG_W-1:0]  idex_rd_reg;

  logic              mem_valid_reg;
  logic [DATA_W-1:0] mem_result_reg;
  logic [REG_W-1:0]  mem_rd_reg;
  logic              mem_illegal_reg;
  logic              z_flag_reg;

  logic              idex_legal;
  logic [DATA_W-1:0] shift_out;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] operand_next;

  assign idex_legal = is_shift_op(idex_opcode_reg);

  Shifter u_shifter (
    .Shift_In  (idex_operand_reg),
    .Shift_val (idex_imm_reg),
    .Mode      (mode_e'(idex_opcode_reg[1:0])),
    .Shift_Out (shift_out)
  );

  // Illegal opcodes flow through with the operand unchanged.
  assign ex_result = idex_legal ? shift_out : idex_operand_reg;

`ifdef SHIFT_EX_FWD_EN
  // Nearest producer wins: the instruction in ID/EX, then the one in EX/MEM.
  always_comb begin
    operand_next = bus.id_rs_data;
    if (bus.id_valid && (bus.id_rs_addr != '0)) begin
      if (idex_valid_reg && idex_legal && (idex_rd_reg == bus.id_rs_addr)) begin
        operand_next = shift_out;
      end else if (mem_valid_reg && !mem_illegal_reg && (mem_rd_reg == bus.id_rs_addr)) begin
        operand_next = mem_result_reg;
      end
    end
  end
`else
  logic unused_rs_addr;
  assign operand_next   = bus.id_rs_data;
  assign unused_rs_addr = ^bus.id_rs_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid_reg   <= 1'b0;
      idex_opcode_reg  <= '0;
      idex_operand_reg <= '0;
      idex_imm_reg     <= '0;
      idex_rd_reg      <= '0;
      mem_valid_reg    <= 1'b0;
      mem_result_reg   <= '0;
      mem_rd_reg       <= '0;
      mem_illegal_reg  <= 1'b0;
      z_flag_reg       <= 1'b0;
    end else begin
      if (!bus.stall) begin
        idex_opcode_reg  <= bus.id_opcode;
        idex_operand_reg <= operand_next;
        idex_imm_reg     <= bus.id_imm;
        idex_rd_reg      <= bus.id_rd;
        mem_result_reg   <= ex_result;
        mem_rd_reg       <= idex_rd_reg;
        mem_illegal_reg  <= idex_valid_reg & ~idex_legal & ~bus.flush;
        if (idex_valid_reg && idex_legal && !bus.flush) begin
          z_flag_reg <= (shift_out == '0);
        end
      end
      // Flush beats stall: both valids drop even while the data fields hold.
      if (bus.flush) begin
        idex_valid_reg  <= 1'b0;
        mem_valid_reg   <= 1'b0;
        mem_illegal_reg <= 1'b0;
      end else if (!bus.stall) begin
        idex_valid_reg <= bus.id_valid;
        mem_valid_reg  <= idex_valid_reg;
      end
    end
  end

  assign bus.mem_valid   = mem_valid_reg;
  assign bus.mem_result  = mem_result_reg;
  assign bus.mem_rd      = mem_rd_reg;
  assign bus.mem_illegal = mem_illegal_reg;
  assign bus.z_flag      = z_flag_reg;

endmodule
